regfile_sweep: RTL and testbench
================================

Name: regfile_sweep

Overview:
Parametrised register file: two asynchronous read ports, one synchronous write port, generalised in data width and depth. Adds a sequential clear engine that zeroes the file one entry per cycle, and a write-drop indication. Sits in the datapath between decode (register addresses) and the ALU/writeback stage.

Parameters:
DATA_W, 8, width of each register and of the data ports
ADDR_W, 2, register address width; depth NUM_REGS = 2**ADDR_W (localparam, not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
read_register_one  input  ADDR_W  read port 1 address
read_register_two  input  ADDR_W  read port 2 address
write_register  input  ADDR_W  write address
write_data  input  DATA_W  write data
reg_write  input  1  write enable
clear_req  input  1  request a full-file clear sweep (level sampled each cycle)
read_data_one  output  DATA_W  contents at read_register_one
read_data_two  output  DATA_W  contents at read_register_two
clear_busy  output  1  high while the sweep is in progress
write_dropped  output  1  registered one-cycle pulse: a write was refused

Behaviour:
- Reset (reset low, asynchronous): all registers 0, FSM IDLE, sweep pointer 0, clear_busy 0, write_dropped 0. Reset mid-sweep aborts the sweep; all entries are 0 anyway.
- Reads: combinational, zero latency, from current register contents. Both ports may address the same register.
- Write (IDLE): reg_write=1 at a rising edge stores write_data into regs[write_register]; visible on read ports the following cycle.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: clear_req=1 at a rising edge. Pointer loads 0, clear_busy goes high that same edge.
  - SWEEP: each edge zeroes regs[pointer] and increments the pointer. At the edge where pointer == NUM_REGS-1, that entry is zeroed, the FSM returns to IDLE, clear_busy drops, and the pointer returns to 0.
  - The sweep takes exactly NUM_REGS cycles with clear_busy high (4 with defaults).
  - clear_req while in SWEEP is ignored; no restart and no extension.
  - clear_req still high on the cycle the FSM returns to IDLE starts a new sweep at the next edge.
- Reads during SWEEP return the partially cleared contents: entries below the pointer read 0, the rest keep their old values.
- Writes during SWEEP: reg_write=1 while clear_busy=1 is not performed. write_dropped=1 for exactly the following cycle, otherwise 0.
- Simultaneous clear_req and reg_write in IDLE: the write is performed at that edge, the sweep starts at that same edge, and the sweep later zeroes the written entry.
- Pointer width is ADDR_W; wrap from NUM_REGS-1 to 0 is implicit.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: while in IDLE, if reg_write=1 and write_register equals a read address, that read port returns write_data combinationally in the same cycle (write-through forwarding). Forwarding is disabled while clear_busy=1.
- Not defined: read ports always return stored contents only; a write is visible the cycle after the edge.

Decomposition:
- Shared package (regfile_pkg): the FSM state enum (IDLE, SWEEP) and default width constants (DATA_W_DEF=8, ADDR_W_DEF=2).
- One sub-module is natural: regfile_sweep_ctrl, containing the FSM, sweep pointer, clear_busy and write_dropped generation. It outputs the sweep write-enable and address to the storage array in the top module.

Test Plan (defaults: DATA_W=8, ADDR_W=2):
1. Reset low, then high; read all four addresses -> all read 0x00; clear_busy=0; write_dropped=0.
2. Write 0xA5 to r2, then 0x3C to r1 in consecutive cycles; read_register_one=2, read_register_two=1 -> 0xA5 and 0x3C, each valid the cycle after its write.
3. Load r0..r3 with 0x11,0x22,0x33,0x44; pulse clear_req -> clear_busy high 4 cycles; after the 2nd sweep edge r0=r1=0x00 while r2=0x33 and r3=0x44; all 0x00 when clear_busy falls.
4. During the sweep, reg_write to r3 with 0xFF -> write_dropped=1 for one cycle; r3 reads 0x00 after the sweep. Second clear_req mid-sweep -> busy still exactly 4 cycles.
5. Assert reset low on the 2nd sweep cycle -> clear_busy=0 immediately (asynchronously); all registers 0x00; a write of 0x5A to r1 after release reads back 0x5A.
6. With REGFILE_BYPASS_EN: reg_write to r1 with 0x77 while read_register_one=1 -> read_data_one=0x77 in the same cycle. Without the macro -> the old value that cycle, 0x77 the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the sweeping register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep controller: FSM, sweep pointer, busy flag and write-drop pulse.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear_req,
  input  logic              i_reg_write,
  output logic              o_clear_busy,
  output logic              o_write_dropped,
  output logic              o_sweep_we_c,
  output logic [ADDR_W-1:0] o_sweep_addr_c
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  sweep_state_e      r_state;
  sweep_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_busy;
  logic              r_dropped;
  logic              w_dropped_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_busy    <= (w_state_nxt == SWEEP);
      r_dropped <= w_dropped_nxt;
    end
  end

  // Requests arriving mid-sweep are ignored; the last entry returns us to IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_dropped_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clear_req) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        w_dropped_nxt = i_reg_write;
        if (r_ptr == ADDR_W'(NUM_REGS - 1)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_clear_busy    = r_busy;
  assign o_write_dropped = r_dropped;
  assign o_sweep_we_c    = (r_state == SWEEP);
  assign o_sweep_addr_c  = r_ptr;

endmodule

// File: rtl/regfile_sweep.sv
// Two-read/one-write register file with sequential clear sweep.
// Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_register_one,
  input  logic [ADDR_W-1:0] read_register_two,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              clear_req,
  output logic [DATA_W-1:0] read_data_one,
  output logic [DATA_W-1:0] read_data_two,
  output logic              clear_busy,
  output logic              write_dropped
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_write_en;

  regfile_sweep_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk             (clk),
    .rst_n           (reset),
    .i_clear_req     (clear_req),
    .i_reg_write     (reg_write),
    .o_clear_busy    (clear_busy),
    .o_write_dropped (write_dropped),
    .o_sweep_we_c    (w_sweep_we),
    .o_sweep_addr_c  (w_sweep_addr)
  );

  assign w_write_en = reg_write && !clear_busy;

  // Sweep has priority; user writes are refused while busy anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_sweep_we) begin
      r_regs[w_sweep_addr] <= '0;
    end else if (w_write_en) begin
      r_regs[write_register] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_data_one = r_regs[read_register_one];
    read_data_two = r_regs[read_register_two];
    if (w_write_en && (write_register == read_register_one)) read_data_one = write_data;
    if (w_write_en && (write_register == read_register_two)) read_data_two = write_data;
  end
`else
  assign read_data_one = r_regs[read_register_one];
  assign read_data_two = r_regs[read_register_two];
`endif

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep with default sizes (DATA_W=8, ADDR_W=2).
module tb_regfile_sweep;

  logic       clk;
  logic       reset;
  logic [1:0] read_register_one;
  logic [1:0] read_register_two;
  logic [1:0] write_register;
  logic [7:0] write_data;
  logic       reg_write;
  logic       clear_req;
  logic [7:0] read_data_one;
  logic [7:0] read_data_two;
  logic       clear_busy;
  logic       write_dropped;

  int tests;
  int errors;

  regfile_sweep dut (
    .clk               (clk),
    .reset             (reset),
    .read_register_one (read_register_one),
    .read_register_two (read_register_two),
    .write_register    (write_register),
    .write_data        (write_data),
    .reg_write         (reg_write),
    .clear_req         (clear_req),
    .read_data_one     (read_data_one),
    .read_data_two     (read_data_two),
    .clear_busy        (clear_busy),
    .write_dropped     (write_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    reg_write      = 1'b1;
    write_register = a;
    write_data     = d;
    step();
    reg_write      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    read_register_one = '0; read_register_two = '0;
    write_register = '0; write_data = '0;
    reg_write = 1'b0; clear_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    tests++;
    if (clear_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", clear_busy);
    end
    tests++;
    if (write_dropped !== 1'b0) begin
      errors++; $display("FAIL reset_dropped: got %b want 0", write_dropped);
    end
    for (int i = 0; i < 4; i++) begin
      read_register_one = 2'(i); read_register_two = 2'(3 - i);
      #1;
      tests++;
      if (read_data_one !== 8'h00 || read_data_two !== 8'h00) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h/%h want 00/00", i, read_data_one, read_data_two);
      end
    end
  endtask

  task automatic test_write();
    reg_write = 1'b1; write_register = 2'd2; write_data = 8'hA5;
    step();
    write_register = 2'd1; write_data = 8'h3C;
    read_register_one = 2'd2; read_register_two = 2'd0;
    #1;
    tests++;
    if (read_data_one !== 8'hA5) begin
      errors++; $display("FAIL write_r2: got %h want a5", read_data_one);
    end
    step();
    reg_write = 1'b0;
    read_register_two = 2'd1;
    #1;
    tests++;
    if (read_data_one !== 8'hA5 || read_data_two !== 8'h3C) begin
      errors++;
      $display("FAIL write_r2_r1: got %h/%h want a5/3c", read_data_one, read_data_two);
    end
  endtask

  task automatic test_sweep();
    write_reg(2'd0, 8'h11); write_reg(2'd1, 8'h22);
    write_reg(2'd2, 8'h33); write_reg(2'd3, 8'h44);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    tests++;
    if (clear_busy !== 1'b1) begin
      errors++; $display("FAIL sweep_busy_e0: got %b want 1", clear_busy);
    end
    step();
    step();
    tests++;
    if (clear_busy !== 1'b1) begin
      errors++; $display("FAIL sweep_busy_e2: got %b want 1", clear_busy);
    end
    read_register_one = 2'd0; read_register_two = 2'd1;
    #1;
    tests++;
    if (read_data_one !== 8'h00 || read_data_two !== 8'h00) begin
      errors++; $display("FAIL sweep_partial_lo: got %h/%h want 00/00", read_data_one, read_data_two);
    end
    read_register_one = 2'd2; read_register_two = 2'd3;
    #1;
    tests++;
    if (read_data_one !== 8'h33 || read_data_two !== 8'h44) begin
      errors++; $display("FAIL sweep_partial_hi: got %h/%h want 33/44", read_data_one, read_data_two);
    end
    step();
    tests++;
    if (clear_busy !== 1'b1) begin
      errors++; $display("FAIL sweep_busy_e3: got %b want 1", clear_busy);
    end
    step();
    tests++;
    if (clear_busy !== 1'b0) begin
      errors++; $display("FAIL sweep_busy_e4: got %b want 0", clear_busy);
    end
    for (int i = 0; i < 4; i++) begin
      read_register_one = 2'(i);
      #1;
      tests++;
      if (read_data_one !== 8'h00) begin
        errors++; $display("FAIL sweep_done[%0d]: got %h want 00", i, read_data_one);
      end
    end
  endtask

  task automatic test_drop_restart();
    int n;
    write_reg(2'd3, 8'h44);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = clear_busy ? 1 : 0;
    reg_write = 1'b1; write_register = 2'd3; write_data = 8'hFF;
    step();
    reg_write = 1'b0;
    if (clear_busy) n++;
    tests++;
    if (write_dropped !== 1'b1) begin
      errors++; $display("FAIL drop_pulse: got %b want 1", write_dropped);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    if (clear_busy) n++;
    tests++;
    if (write_dropped !== 1'b0) begin
      errors++; $display("FAIL drop_single: got %b want 0", write_dropped);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (clear_busy) n++;
      else break;
    end
    tests++;
    if (n != 4 || clear_busy !== 1'b0) begin
      errors++; $display("FAIL restart_busy_len: got %0d cycles busy=%b want 4 busy=0", n, clear_busy);
    end
    read_register_two = 2'd3;
    #1;
    tests++;
    if (read_data_two !== 8'h00) begin
      errors++; $display("FAIL drop_r3: got %h want 00", read_data_two);
    end
  endtask

  task automatic test_reset_mid_sweep();
    write_reg(2'd1, 8'h99); write_reg(2'd2, 8'h66); write_reg(2'd3, 8'h12);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (clear_busy !== 1'b0 || write_dropped !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got busy=%b drop=%b want 0/0", clear_busy, write_dropped);
    end
    for (int i = 0; i < 4; i++) begin
      read_register_one = 2'(i);
      #1;
      tests++;
      if (read_data_one !== 8'h00) begin
        errors++; $display("FAIL rstmid_read[%0d]: got %h want 00", i, read_data_one);
      end
    end
    reset = 1'b1;
    step();
    write_reg(2'd1, 8'h5A);
    read_register_one = 2'd1;
    #1;
    tests++;
    if (read_data_one !== 8'h5A || clear_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_write: got %h busy=%b want 5a busy=0", read_data_one, clear_busy);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_same;
    write_reg(2'd1, 8'h10);
`ifdef REGFILE_BYPASS_EN
    exp_same = 8'h77;
`else
    exp_same = 8'h10;
`endif
    reg_write = 1'b1; write_register = 2'd1; write_data = 8'h77;
    read_register_one = 2'd1; read_register_two = 2'd0;
    #1;
    tests++;
    if (read_data_one !== exp_same) begin
      errors++; $display("FAIL bypass_same_cycle: got %h want %h", read_data_one, exp_same);
    end
    step();
    reg_write = 1'b0;
    #1;
    tests++;
    if (read_data_one !== 8'h77) begin
      errors++; $display("FAIL bypass_next_cycle: got %h want 77", read_data_one);
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_write();
    test_sweep();
    test_drop_restart();
    test_reset_mid_sweep();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
